// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl - frame sequencer wrapped around the streaming FFT core.
//
// Gates the sample stream into the core and the result stream out of it so
// that every frame is exactly N_POINTS samples in followed by exactly
// N_POINTS results out. Counts completed frames, flags the last result of
// each frame and reports busy / done / error status.
//
// Compile-time option:
//   FFT_FRAME_CTRL_WDOG_EN - adds an UNLOAD watchdog. When the core stops
//                            offering results for TIMEOUT cycles the run is
//                            dropped and the sticky o_err flag is set.
//                            Without it o_err stays 0 and UNLOAD waits forever.

module fft_frame_ctrl #(
  parameter int N_POINTS = 256,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [15:0]       i_num_frames,
  // upstream sample stream
  input  logic              i_src_valid,
  input  logic [DATA_W-1:0] i_src_data,
  output logic              o_src_ready,
  // samples into the FFT core
  output logic              o_fft_valid,
  output logic [DATA_W-1:0] o_fft_data,
  input  logic              i_fft_ready,
  // results out of the FFT core
  input  logic              i_fft_valid,
  input  logic [DATA_W-1:0] i_fft_data,
  output logic              o_fft_ready,
  // downstream result stream
  output logic              o_dst_valid,
  output logic [DATA_W-1:0] o_dst_data,
  output logic              o_dst_last,
  input  logic              i_dst_ready,
  // status
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_frame_cnt,
  output logic              o_err
);

  localparam int CNT_W = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_POINTS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_UNLOAD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_in_cnt;
  logic [CNT_W-1:0]  w_in_cnt_nxt;
  logic [CNT_W-1:0]  r_out_cnt;
  logic [CNT_W-1:0]  w_out_cnt_nxt;
  logic [15:0]       r_frame_cnt;
  logic [15:0]       w_frame_cnt_nxt;
  logic [15:0]       w_frame_inc;
  logic [15:0]       r_num_frames;
  logic [15:0]       w_num_frames_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              r_busy;
  logic              w_src_hs;
  logic              w_dst_hs;
  logic              w_wdog_trip;

  // A handshake only counts while the matching phase owns the stream.
  assign w_src_hs    = (r_state == S_LOAD)   & i_src_valid & i_fft_ready;
  assign w_dst_hs    = (r_state == S_UNLOAD) & i_fft_valid & i_dst_ready;
  assign w_frame_inc = r_frame_cnt + 16'd1;

`ifdef FFT_FRAME_CTRL_WDOG_EN
  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_ZERO = WDOG_W'(0);
  localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] r_wdog;
  logic [WDOG_W-1:0] w_wdog_nxt;

  // Watchdog: counts UNLOAD cycles with no result offered; back-pressure from the sink is not the core's fault.
  always_comb begin
    w_wdog_nxt  = r_wdog;
    w_wdog_trip = 1'b0;
    if ((r_state != S_UNLOAD) || i_abort) begin
      w_wdog_nxt = WDOG_ZERO;
    end else if (w_dst_hs) begin
      w_wdog_nxt = WDOG_ZERO;
    end else if (!i_fft_valid) begin
      if (r_wdog == WDOG_LAST) begin
        w_wdog_trip = 1'b1;
        w_wdog_nxt  = WDOG_ZERO;
      end else begin
        w_wdog_nxt  = r_wdog + WDOG_ONE;
      end
    end else begin
      w_wdog_nxt = r_wdog;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wdog <= WDOG_ZERO;
    end else begin
      r_wdog <= w_wdog_nxt;
    end
  end
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT;
  assign w_wdog_trip      = 1'b0;
`endif

  // Stream gating: pass valid/ready/data straight through for the active phase only.
  always_comb begin
    o_src_ready = 1'b0;
    o_fft_valid = 1'b0;
    o_fft_ready = 1'b0;
    o_dst_valid = 1'b0;
    o_dst_last  = 1'b0;
    o_fft_data  = i_src_data;
    o_dst_data  = i_fft_data;
    case (r_state)
      S_IDLE: begin
        o_src_ready = 1'b0;
        o_dst_valid = 1'b0;
      end
      S_LOAD: begin
        o_fft_valid = i_src_valid;
        o_src_ready = i_fft_ready;
      end
      S_UNLOAD: begin
        o_dst_valid = i_fft_valid;
        o_fft_ready = i_dst_ready;
        o_dst_last  = i_fft_valid & (r_out_cnt == CNT_LAST);
      end
      default: begin
        o_src_ready = 1'b0;
        o_dst_valid = 1'b0;
      end
    endcase
  end

  // Next-state and counter update; abort overrides every other transition.
  always_comb begin
    w_state_nxt      = r_state;
    w_in_cnt_nxt     = r_in_cnt;
    w_out_cnt_nxt    = r_out_cnt;
    w_frame_cnt_nxt  = r_frame_cnt;
    w_num_frames_nxt = r_num_frames;
    w_done_nxt       = 1'b0;
    w_err_nxt        = r_err;
    if (i_abort) begin
      // frame count and error flag are kept so software can see how far the run got
      w_state_nxt   = S_IDLE;
      w_in_cnt_nxt  = CNT_ZERO;
      w_out_cnt_nxt = CNT_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_state_nxt      = S_LOAD;
            w_in_cnt_nxt     = CNT_ZERO;
            w_out_cnt_nxt    = CNT_ZERO;
            w_frame_cnt_nxt  = 16'd0;
            w_err_nxt        = 1'b0;
            w_num_frames_nxt = i_num_frames;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_LOAD: begin
          if (w_src_hs) begin
            if (r_in_cnt == CNT_LAST) begin
              w_in_cnt_nxt = CNT_ZERO;
              w_state_nxt  = S_UNLOAD;
            end else begin
              w_in_cnt_nxt = r_in_cnt + CNT_ONE;
            end
          end else begin
            w_state_nxt = S_LOAD;
          end
        end
        S_UNLOAD: begin
          if (w_dst_hs) begin
            if (r_out_cnt == CNT_LAST) begin
              w_out_cnt_nxt   = CNT_ZERO;
              w_frame_cnt_nxt = w_frame_inc;
              // a zero frame limit means continuous mode: never stop by count
              if ((r_num_frames != 16'd0) && (w_frame_inc == r_num_frames)) begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
              end else begin
                w_state_nxt = S_LOAD;
              end
            end else begin
              w_out_cnt_nxt = r_out_cnt + CNT_ONE;
            end
          end else if (w_wdog_trip) begin
            w_state_nxt   = S_IDLE;
            w_out_cnt_nxt = CNT_ZERO;
            w_err_nxt     = 1'b1;
          end else begin
            w_state_nxt = S_UNLOAD;
          end
        end
        default: begin
          w_state_nxt   = S_IDLE;
          w_in_cnt_nxt  = CNT_ZERO;
          w_out_cnt_nxt = CNT_ZERO;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sample/result counters, frame bookkeeping and registered status flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_in_cnt     <= CNT_ZERO;
      r_out_cnt    <= CNT_ZERO;
      r_frame_cnt  <= 16'd0;
      r_num_frames <= 16'd0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_in_cnt     <= w_in_cnt_nxt;
      r_out_cnt    <= w_out_cnt_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
      r_num_frames <= w_num_frames_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_frame_cnt = r_frame_cnt;
  assign o_err       = r_err;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl (N_POINTS=8, TIMEOUT=16).
// The bench plays the FFT core: it stores every accepted sample and returns
// its bitwise inverse as the result, so each result is traceable to a sample.
module tb_fft_frame_ctrl;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          i_clk, i_rst, i_start, i_abort;
  logic [15:0]   i_num_frames;
  logic          i_src_valid, o_src_ready;
  logic [DW-1:0] i_src_data;
  logic          o_fft_valid, i_fft_ready;
  logic [DW-1:0] o_fft_data;
  logic          i_fft_valid, o_fft_ready;
  logic [DW-1:0] i_fft_data;
  logic          o_dst_valid, o_dst_last, i_dst_ready;
  logic [DW-1:0] o_dst_data;
  logic          o_busy, o_done, o_err;
  logic [15:0]   o_frame_cnt;

  fft_frame_ctrl #(.N_POINTS(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_num_frames(i_num_frames),
    .i_src_valid(i_src_valid), .i_src_data(i_src_data), .o_src_ready(o_src_ready),
    .o_fft_valid(o_fft_valid), .o_fft_data(o_fft_data), .i_fft_ready(i_fft_ready),
    .i_fft_valid(i_fft_valid), .i_fft_data(i_fft_data), .o_fft_ready(o_fft_ready),
    .o_dst_valid(o_dst_valid), .o_dst_data(o_dst_data), .o_dst_last(o_dst_last),
    .i_dst_ready(i_dst_ready),
    .o_busy(o_busy), .o_done(o_done), .o_frame_cnt(o_frame_cnt), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard state
  logic [31:0] core_q[$];
  logic [32:0] exp_q[$];
  int n_in, n_out, n_last, n_done, done_k, busy_k0;
  bit timed_out;

  task automatic idle_in();
    i_start = 1'b0; i_abort = 1'b0;
    i_src_valid = 1'b0; i_src_data = 32'h0; i_fft_ready = 1'b0;
    i_fft_valid = 1'b0; i_fft_data = 32'h0; i_dst_ready = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] nf);
    i_num_frames = nf;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  // Drive source and core, push expectations on accepted samples, pop on delivered results.
  task automatic stream(input bit rnd, input int stop_in, input int start_at, input int max_cyc);
    int k;
    logic [32:0] e;
    logic [31:0] sd;
    core_q.delete(); exp_q.delete();
    n_in = 0; n_out = 0; n_last = 0; n_done = 0; done_k = -1; busy_k0 = -1; timed_out = 1'b0;
    k = 0;
    while (1) begin
      i_start = (k == start_at);
      if (k == start_at) i_num_frames = 16'd5;
      i_src_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_src_data  = 32'hC0DE_0000 + 32'(n_in);
      i_fft_ready = 1'b1;
      i_fft_valid = (core_q.size() != 0) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      i_fft_data  = (core_q.size() != 0) ? ~core_q[0] : 32'h0;
      i_dst_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      #3;
      if (k == 0) busy_k0 = int'(o_busy);
      if (i_src_valid && o_src_ready) begin
        chk("fft_data_pass", o_fft_data, i_src_data);
        core_q.push_back(i_src_data);
        exp_q.push_back({((n_in % N) == N - 1), ~i_src_data});
        n_in++;
      end
      if (o_dst_valid && i_dst_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          e  = exp_q.pop_front();
          sd = core_q.pop_front();
          chk("dst_data", o_dst_data, e[31:0]);
          chk("dst_last", 32'(o_dst_last), 32'(e[32]));
        end
        n_out++;
        if (o_dst_last) n_last++;
      end
      if (o_done) begin
        n_done++;
        done_k = k;
        chk("busy_low_at_done", 32'(o_busy), 32'd0);
      end
      @(posedge i_clk); #1;
      i_start = 1'b0;
      k++;
      if ((n_done > 0) || ((stop_in > 0) && (n_in == stop_in))) break;
      if (k >= max_cyc) begin
        timed_out = 1'b1;
        break;
      end
    end
    chk("stream_budget", 32'(timed_out), 32'd0);
  endtask

  typedef struct {
    int          st;
    logic        src_v, fft_rdy, fft_v, dst_rdy;
    logic [31:0] sdata, fdata;
    logic        e_src_rdy, e_fft_v, e_fft_rdy, e_dst_v;
  } vec_t;
  vec_t vt[10];

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    // state 0 = IDLE, 1 = LOAD, 2 = UNLOAD; none of these vectors completes a handshake
    vt[0] = '{0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3333_3333, 32'h4444_4444, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h5555_5555, 32'h6666_6666, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7777_7777, 32'h8888_8888, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 32'h5A5A_0001, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[5] = '{1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0002, 32'h5A5A_0002, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA5A5_0003, 32'h5A5A_0003, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7] = '{2, 1'b1, 1'b1, 1'b1, 1'b0, 32'hB4B4_0001, 32'h4B4B_0001, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[8] = '{2, 1'b1, 1'b1, 1'b0, 1'b1, 32'hB4B4_0002, 32'h4B4B_0002, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[9] = '{2, 1'b0, 1'b0, 1'b0, 1'b0, 32'hB4B4_0003, 32'h4B4B_0003, 1'b0, 1'b0, 1'b0, 1'b0};

    // ---- reset state ----
    idle_in();
    i_num_frames = 16'd0;
    i_rst = 1'b1;
    i_src_valid = 1'b1; i_fft_ready = 1'b1; i_fft_valid = 1'b1; i_dst_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_src_ready", 32'(o_src_ready), 32'd0);
    chk("rst_fft_valid", 32'(o_fft_valid), 32'd0);
    chk("rst_fft_ready", 32'(o_fft_ready), 32'd0);
    chk("rst_dst_valid", 32'(o_dst_valid), 32'd0);
    i_rst = 1'b0;
    idle_in();
    @(posedge i_clk); #1;

    // ---- table-driven gating checks per state ----
    begin
      int cur;
      cur = 0;
      for (int i = 0; i < 10; i++) begin
        if (vt[i].st != cur) begin
          if (vt[i].st == 1) begin
            do_start(16'd1);
          end else begin
            i_src_valid = 1'b1; i_fft_ready = 1'b1; i_fft_valid = 1'b0; i_dst_ready = 1'b0;
            repeat (N) begin @(posedge i_clk); #1; end
            i_src_valid = 1'b0;
          end
          cur = vt[i].st;
        end
        i_src_valid = vt[i].src_v; i_fft_ready = vt[i].fft_rdy;
        i_fft_valid = vt[i].fft_v; i_dst_ready = vt[i].dst_rdy;
        i_src_data  = vt[i].sdata; i_fft_data  = vt[i].fdata;
        #2;
        chk($sformatf("v%0d_src_ready", i), 32'(o_src_ready), 32'(vt[i].e_src_rdy));
        chk($sformatf("v%0d_fft_valid", i), 32'(o_fft_valid), 32'(vt[i].e_fft_v));
        chk($sformatf("v%0d_fft_ready", i), 32'(o_fft_ready), 32'(vt[i].e_fft_rdy));
        chk($sformatf("v%0d_dst_valid", i), 32'(o_dst_valid), 32'(vt[i].e_dst_v));
        chk($sformatf("v%0d_dst_last", i), 32'(o_dst_last), 32'd0);
        if (vt[i].e_fft_v) chk($sformatf("v%0d_fft_data", i), o_fft_data, vt[i].sdata);
        if (vt[i].e_dst_v) chk($sformatf("v%0d_dst_data", i), o_dst_data, vt[i].fdata);
        @(posedge i_clk); #1;
      end
      i_abort = 1'b1;
      @(posedge i_clk); #1;
      i_abort = 1'b0;
      chk("tbl_abort_busy", 32'(o_busy), 32'd0);
    end

    // ---- single frame, always ready ----
    do_start(16'd1);
    stream(1'b0, 0, -1, 200);
    chk("t1_in", 32'(n_in), 32'd8);
    chk("t1_out", 32'(n_out), 32'd8);
    chk("t1_last", 32'(n_last), 32'd1);
    chk("t1_done", 32'(n_done), 32'd1);
    chk("t1_done_cycle", 32'(done_k + 1), 32'(1 + 2 * N));
    chk("t1_busy_first", 32'(busy_k0), 32'd1);
    chk("t1_frame_cnt", 32'(o_frame_cnt), 32'd1);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    #1;
    chk("t1_done_one_cycle", 32'(o_done), 32'd0);
    chk("t1_src_ready_idle", 32'(o_src_ready), 32'd0);
    @(posedge i_clk); #1;

    // ---- three frames with random stalls ----
    do_start(16'd3);
    stream(1'b1, 0, -1, 3000);
    chk("t2_in", 32'(n_in), 32'd24);
    chk("t2_out", 32'(n_out), 32'd24);
    chk("t2_last", 32'(n_last), 32'd3);
    chk("t2_done", 32'(n_done), 32'd1);
    chk("t2_frame_cnt", 32'(o_frame_cnt), 32'd3);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);
    #1;
    chk("t2_done_one_cycle", 32'(o_done), 32'd0);
    @(posedge i_clk); #1;

    // ---- continuous mode, abort mid-LOAD of frame 6 at in_cnt=4 ----
    do_start(16'd0);
    stream(1'b0, 5 * N + 4, -1, 500);
    chk("t3_in", 32'(n_in), 32'd44);
    chk("t3_out", 32'(n_out), 32'd40);
    chk("t3_last", 32'(n_last), 32'd5);
    chk("t3_no_done", 32'(n_done), 32'd0);
    chk("t3_frame_cnt_pre", 32'(o_frame_cnt), 32'd5);
    i_abort = 1'b1; i_src_valid = 1'b0;
    @(posedge i_clk); #1;
    i_abort = 1'b0; i_src_valid = 1'b1; i_fft_ready = 1'b1;
    #1;
    chk("t3_abort_busy", 32'(o_busy), 32'd0);
    chk("t3_abort_src_ready", 32'(o_src_ready), 32'd0);
    chk("t3_abort_frame_cnt", 32'(o_frame_cnt), 32'd5);
    chk("t3_abort_done", 32'(o_done), 32'd0);
    @(posedge i_clk); #1;
    chk("t3_abort_done_next", 32'(o_done), 32'd0);
    do_start(16'd1);
    chk("t3_restart_frame_cnt", 32'(o_frame_cnt), 32'd0);
    stream(1'b0, 0, -1, 200);
    chk("t3_restart_in", 32'(n_in), 32'd8);
    chk("t3_restart_last", 32'(n_last), 32'd1);
    chk("t3_restart_done_cycle", 32'(done_k + 1), 32'(1 + 2 * N));
    chk("t3_restart_frame_cnt_end", 32'(o_frame_cnt), 32'd1);
    @(posedge i_clk); #1;

    // ---- start while busy is ignored ----
    do_start(16'd1);
    stream(1'b0, 0, 3, 200);
    chk("t4_in", 32'(n_in), 32'd8);
    chk("t4_done", 32'(n_done), 32'd1);
    chk("t4_done_cycle", 32'(done_k + 1), 32'(1 + 2 * N));
    chk("t4_frame_cnt", 32'(o_frame_cnt), 32'd1);

    // ---- start and abort together in IDLE ----
    i_num_frames = 16'd1;
    i_start = 1'b1; i_abort = 1'b1; i_src_valid = 1'b1; i_fft_ready = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_abort = 1'b0;
    #1;
    chk("t5_busy", 32'(o_busy), 32'd0);
    chk("t5_src_ready", 32'(o_src_ready), 32'd0);
    chk("t5_frame_cnt_held", 32'(o_frame_cnt), 32'd1);
    @(posedge i_clk); #1;
    chk("t5_busy_next", 32'(o_busy), 32'd0);

    // ---- UNLOAD stall behaviour ----
`ifdef FFT_FRAME_CTRL_WDOG_EN
    do_start(16'd1);
    stream(1'b0, N, -1, 100);
    i_src_valid = 1'b0; i_fft_valid = 1'b0; i_dst_ready = 1'b1;
    repeat (TO - 1) begin @(posedge i_clk); #1; end
    chk("wd_pre_busy", 32'(o_busy), 32'd1);
    chk("wd_pre_err", 32'(o_err), 32'd0);
    @(posedge i_clk); #1;
    chk("wd_err", 32'(o_err), 32'd1);
    chk("wd_busy", 32'(o_busy), 32'd0);
    chk("wd_no_done", 32'(o_done), 32'd0);
    @(posedge i_clk); #1;
    chk("wd_err_sticky", 32'(o_err), 32'd1);
    do_start(16'd1);
    chk("wd_err_cleared", 32'(o_err), 32'd0);
    stream(1'b0, N, -1, 100);
    i_src_valid = 1'b0; i_fft_valid = 1'b1; i_fft_data = 32'h1234_5678; i_dst_ready = 1'b0;
    repeat (100) begin @(posedge i_clk); #1; end
    chk("wd_backpressure_err", 32'(o_err), 32'd0);
    chk("wd_backpressure_busy", 32'(o_busy), 32'd1);
`else
    do_start(16'd1);
    stream(1'b0, N, -1, 100);
    i_src_valid = 1'b0; i_fft_valid = 1'b0; i_dst_ready = 1'b1;
    repeat (3 * TO) begin @(posedge i_clk); #1; end
    chk("nowd_err", 32'(o_err), 32'd0);
    chk("nowd_busy", 32'(o_busy), 32'd1);
`endif
    i_abort = 1'b1;
    @(posedge i_clk); #1;
    i_abort = 1'b0;
    chk("stall_abort_busy", 32'(o_busy), 32'd0);

    // ---- asynchronous reset in the middle of UNLOAD ----
    do_start(16'd2);
    stream(1'b0, 2 * N, -1, 200);
    i_fft_valid = 1'b1; i_fft_data = 32'hDEAD_BEEF; i_dst_ready = 1'b1;
    i_src_valid = 1'b1; i_fft_ready = 1'b1;
    #1;
    chk("ar_pre_dst_valid", 32'(o_dst_valid), 32'd1);
    chk("ar_pre_frame_cnt", 32'(o_frame_cnt), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("ar_busy", 32'(o_busy), 32'd0);
    chk("ar_done", 32'(o_done), 32'd0);
    chk("ar_frame_cnt", 32'(o_frame_cnt), 32'd0);
    chk("ar_err", 32'(o_err), 32'd0);
    chk("ar_dst_valid", 32'(o_dst_valid), 32'd0);
    chk("ar_dst_last", 32'(o_dst_last), 32'd0);
    chk("ar_fft_ready", 32'(o_fft_ready), 32'd0);
    chk("ar_src_ready", 32'(o_src_ready), 32'd0);
    chk("ar_fft_valid", 32'(o_fft_valid), 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    idle_in();
    @(posedge i_clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer for the streaming FFT core. It sits between the 32-bit sample source and `fft_computer`, and between `fft_computer` and the result sink. It gates the core's input and output handshakes so each frame is exactly N_POINTS samples in and N_POINTS results out, in strict alternation. It also counts frames, marks the last result of each frame, and reports busy/done/error status to the register interface.

## Interface
- N_POINTS, 256, samples per FFT frame; a power of two, at least 2.
- DATA_W, 32, sample width.
- TIMEOUT, 4096, watchdog limit in cycles; used only when the watchdog is compiled in.

- i_clk, in, 1, sole clock; all state is updated on its rising edge.
- i_rst, in, 1, asynchronous active-high reset.
- i_start, in, 1, one-cycle start request; ignored while o_busy=1.
- i_abort, in, 1, return to IDLE at the next edge.
- i_num_frames, in, 16, frames per run, sampled on start; 0 means continuous.
- i_src_valid / i_src_data / o_src_ready, in/in/out, 1/DATA_W/1, upstream sample stream.
- o_fft_valid / o_fft_data / i_fft_ready, out/out/in, 1/DATA_W/1, samples into `fft_computer`.
- i_fft_valid / i_fft_data / o_fft_ready, in/in/out, 1/DATA_W/1, results out of `fft_computer`.
- o_dst_valid / o_dst_data / o_dst_last / i_dst_ready, out/out/out/in, 1/DATA_W/1/1, downstream result stream.
- o_busy, out, 1, high in LOAD or UNLOAD.
- o_done, out, 1, one-cycle pulse at the end of a run.
- o_frame_cnt, out, 16, frames completed in the current run.
- o_err, out, 1, sticky watchdog error.

## Operation
- The data path is combinational pass-through. Only the control logic is registered.
- States: IDLE, LOAD, UNLOAD. Reset enters IDLE.
- IDLE:
  - All ready/valid outputs are 0.
  - i_start=1 → LOAD; clears in_cnt, out_cnt, o_frame_cnt and o_err; latches i_num_frames.
- LOAD:
  - o_fft_valid=i_src_valid, o_src_ready=i_fft_ready, o_fft_data=i_src_data.
  - o_fft_ready=0, o_dst_valid=0.
  - Each source handshake increments in_cnt (width $clog2(N_POINTS)).
  - Handshake with in_cnt=N_POINTS-1 → UNLOAD, in_cnt wraps to 0.
- UNLOAD:
  - o_dst_valid=i_fft_valid, o_fft_ready=i_dst_ready, o_dst_data=i_fft_data.
  - o_dst_last=(out_cnt==N_POINTS-1) while o_dst_valid=1.
  - o_src_ready=0, o_fft_valid=0.
  - Each sink handshake increments out_cnt.
  - Last handshake: out_cnt→0, o_frame_cnt+1.
  - If latched frames≠0 and the new count equals it → IDLE with o_done=1 on the following cycle.
  - Otherwise → LOAD.
- Continuous mode (latched frames=0): o_frame_cnt wraps from 0xFFFF to 0 and the run never ends by count.
- i_abort has priority over every transition. Any state → IDLE; counters clear except o_frame_cnt, which holds; no o_done.
- i_abort and i_start in the same cycle in IDLE: abort wins and the state stays IDLE.

## Timing
- Reset values: state IDLE, o_busy=0, o_done=0, o_frame_cnt=0, o_err=0, counters 0, all valid/ready outputs 0.
- Zero-cycle handshake latency: ready and valid pass through in the same cycle.
- Throughput: one sample per cycle in LOAD and one result per cycle in UNLOAD when both sides are ready.
- The LOAD→UNLOAD and UNLOAD→LOAD switches take effect on the edge of the completing handshake. There is no bubble cycle.
- o_busy is registered: high the cycle after i_start is accepted, low the same cycle o_done pulses.
- A minimal single frame with no stalls takes 1 + 2·N_POINTS cycles from i_start to o_done.

## Configuration
- FFT_FRAME_CTRL_WDOG_EN defined:
  - In UNLOAD, a counter increments every cycle with i_fft_valid=0 and clears on every sink handshake.
  - Cycles with i_fft_valid=1 and i_dst_ready=0 do not count.
  - Reaching TIMEOUT → IDLE, o_err=1 (sticky until the next accepted i_start), no o_done.
- Not defined: o_err is tied to 0 and UNLOAD waits indefinitely.

## Test plan
- N_POINTS=8, i_num_frames=1, all sides always ready:
  - 8 samples pass; o_src_ready drops after the 8th.
  - 8 results pass with o_dst_last on the 8th only.
  - o_done pulses once; o_frame_cnt=1.
- i_num_frames=3 with random stalls on i_src_valid and i_dst_ready: exactly 24 samples in and 24 out, o_dst_last count=3, o_frame_cnt=3, one o_done.
- i_num_frames=0:
  - Runs 5 frames, then i_abort mid-LOAD at in_cnt=4 → IDLE next cycle, o_frame_cnt=5, no o_done.
  - A new i_start restarts with in_cnt=0.
- i_start while busy is ignored; i_start and i_abort together in IDLE leave the block in IDLE.
- WDOG_EN, TIMEOUT=16: hold i_fft_valid=0 in UNLOAD → o_err=1 after 16 cycles, state IDLE; holding i_dst_ready=0 with i_fft_valid=1 for 100 cycles raises no error.
- Async reset asserted mid-UNLOAD → all outputs return to reset values immediately, without waiting for a clock edge.
